// File: rtl/multibyte_add_ctrl.sv
// multibyte_add_ctrl
//   Drives an external 8-bit adder one byte per cycle, LSB first. It adds or
//   subtracts two NBYTES-wide operands and reports the result and flags with
//   a one-cycle done pulse. Each byte's carry is registered and becomes the
//   carry-in of the next byte. Subtraction is A + ~B + 1: B is inverted byte
//   by byte, and the first carry-in is seeded with 1.
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   start, sub       request (taken only in idle) and op select (1 = A-B)
//   OpA, OpB         operands, sampled together with start
//   busy, done       byte sequence in progress / one-cycle result-valid pulse
//   Result           W-bit sum or difference
//   CarryOut         final byte carry (sub: 1 = no borrow)
//   Overflow, Zero   signed overflow of the full op / Result == 0
//   AddA/AddB/AddCin operands to the 8-bit adder
//   AddSum/AddCout/AddOverflow combinational return from the 8-bit adder
module multibyte_add_ctrl #(
    parameter int unsigned NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  sub,
    input  logic [8*NBYTES-1:0]   OpA,
    input  logic [8*NBYTES-1:0]   OpB,
    output logic                  busy,
    output logic                  done,
    output logic [8*NBYTES-1:0]   Result,
    output logic                  CarryOut,
    output logic                  Overflow,
    output logic                  Zero,
    output logic [7:0]            AddA,
    output logic [7:0]            AddB,
    output logic                  AddCin,
    input  logic [7:0]            AddSum,
    input  logic                  AddCout,
    input  logic                  AddOverflow
);

    localparam int unsigned IdxW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NBYTES - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e                   state_q, state_d;
    logic [IdxW-1:0]          idx_q, idx_d;
    logic                     carry_q, carry_d;
    logic                     sub_q, sub_d;
    logic [NBYTES-1:0][7:0]   opa_q, opa_d;
    logic [NBYTES-1:0][7:0]   opb_q, opb_d;
    logic [NBYTES-1:0][7:0]   result_q, result_d;
    logic                     cout_q, cout_d;
    logic                     ovf_q, ovf_d;
    logic                     zero_q, zero_d;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        sub_d    = sub_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        AddA     = 8'h00;
        AddB     = 8'h00;
        AddCin   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    opa_d   = OpA;
                    opb_d   = OpB;
                    sub_d   = sub;
                    idx_d   = '0;
                    carry_d = sub;  // +1 of the two's complement for A-B
                    state_d = StRun;
                end
            end
            StRun: begin
                AddA             = opa_q[idx_q];
                AddB             = opb_q[idx_q] ^ {8{sub_q}};
                AddCin           = carry_q;
                result_d[idx_q]  = AddSum;
                carry_d          = AddCout;
                if (idx_q == LastIdx) begin
                    cout_d  = AddCout;
                    ovf_d   = AddOverflow;
                    // Includes the top byte being written this edge.
                    zero_d  = (result_d == '0);
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            sub_q    <= 1'b0;
            opa_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            sub_q    <= sub_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    assign busy     = (state_q == StRun);
    assign done     = (state_q == StDone);
    assign Result   = result_q;
    assign CarryOut = cout_q;
    assign Overflow = ovf_q;
    assign Zero     = zero_q;

endmodule

// File: tb/tb_multibyte_add_ctrl.sv
module tb_multibyte_add_ctrl;

    localparam int unsigned NB = 4;
    localparam int unsigned W  = 8 * NB;

    logic         clk;
    logic         rst;
    logic         start;
    logic         sub;
    logic [W-1:0] OpA;
    logic [W-1:0] OpB;
    logic         busy;
    logic         done;
    logic [W-1:0] Result;
    logic         CarryOut;
    logic         Overflow;
    logic         Zero;
    logic [7:0]   AddA;
    logic [7:0]   AddB;
    logic         AddCin;
    logic [7:0]   AddSum;
    logic         AddCout;
    logic         AddOverflow;

    int checks;
    int failures;

    multibyte_add_ctrl #(.NBYTES(NB)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .sub        (sub),
        .OpA        (OpA),
        .OpB        (OpB),
        .busy       (busy),
        .done       (done),
        .Result     (Result),
        .CarryOut   (CarryOut),
        .Overflow   (Overflow),
        .Zero       (Zero),
        .AddA       (AddA),
        .AddB       (AddB),
        .AddCin     (AddCin),
        .AddSum     (AddSum),
        .AddCout    (AddCout),
        .AddOverflow(AddOverflow)
    );

    // Behavioural 8-bit adder standing in for adder_8bit.
    logic [8:0] add_full;
    assign add_full    = {1'b0, AddA} + {1'b0, AddB} + {8'd0, AddCin};
    assign AddSum      = add_full[7:0];
    assign AddCout     = add_full[8];
    assign AddOverflow = (AddA[7] == AddB[7]) && (AddSum[7] != AddA[7]);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge in an idle cycle; returns at the negedge of the idle
    // cycle following done. With hold=1, start stays high with fresh random
    // operands through the run and done cycles, which must be ignored.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input bit hold);
        logic [W-1:0] bm;
        logic [32:0]  full;
        logic [63:0]  mask;
        logic [63:0]  lo;
        logic         exp_ovf;
        bm      = s ? ~b : b;
        full    = {1'b0, a} + {1'b0, bm} + 33'(s);
        exp_ovf = (a[W-1] == bm[W-1]) && (full[W-1] != a[W-1]);
        OpA = a; OpB = b; sub = s; start = 1'b1;
        @(negedge clk);
        for (int i = 0; i < NB; i++) begin
            mask = (64'd1 << (8 * i)) - 64'd1;
            lo   = (64'(a) & mask) + (64'(bm) & mask) + 64'(s);
            chk($sformatf("busy_run%0d", i), 64'(busy), 64'd1);
            chk($sformatf("done_run%0d", i), 64'(done), 64'd0);
            chk($sformatf("add_a%0d", i), 64'(AddA), 64'((a >> (8 * i)) & 32'hFF));
            chk($sformatf("add_b%0d", i), 64'(AddB), 64'((bm >> (8 * i)) & 32'hFF));
            chk($sformatf("add_cin%0d", i), 64'(AddCin), (lo >> (8 * i)) & 64'd1);
            if (hold) begin
                start = 1'b1; OpA = $urandom; OpB = $urandom; sub = 1'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        chk("done_pulse", 64'(done), 64'd1);
        chk("busy_done", 64'(busy), 64'd0);
        chk("result", 64'(Result), 64'(full[W-1:0]));
        chk("carry_out", 64'(CarryOut), 64'(full[W]));
        chk("overflow", 64'(Overflow), 64'(exp_ovf));
        chk("zero", 64'(Zero), 64'(full[W-1:0] == '0));
        chk("add_idle", {AddA, AddB, 7'd0, AddCin}, 64'd0);
        start = 1'b0;
        @(negedge clk);
        chk("done_single", 64'(done), 64'd0);
        chk("busy_after", 64'(busy), 64'd0);
        chk("result_hold", 64'(Result), 64'(full[W-1:0]));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst = 1'b1; start = 1'b0; sub = 1'b0; OpA = '0; OpB = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_result", 64'(Result), 64'd0);
        chk("rst_flags", {61'd0, CarryOut, Overflow, Zero}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op(32'h000000FF, 32'h00000001, 1'b0, 1'b0);
        run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0);
        run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0);
        run_op(32'h00000005, 32'h00000007, 1'b1, 1'b0);
        run_op(32'h80000000, 32'h00000001, 1'b1, 1'b0);
        // Start held through run; next op issued back-to-back from idle.
        run_op(32'h12345678, 32'h0FEDCBA9, 1'b0, 1'b1);
        run_op(32'h00000000, 32'h00000000, 1'b1, 1'b0);

        // Reset during the second run cycle.
        OpA = 32'hDEADBEEF; OpB = 32'h01234567; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_done", 64'(done), 64'd0);
        chk("mid_rst_result", 64'(Result), 64'd0);
        chk("mid_rst_flags", {61'd0, CarryOut, Overflow, Zero}, 64'd0);
        chk("mid_rst_add", {AddA, AddB, 7'd0, AddCin}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        run_op(32'hDEADBEEF, 32'h01234567, 1'b1, 1'b0);

        for (int n = 0; n < 30; n++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = $urandom;
            rb = (n % 5 == 0) ? ra : W'($urandom);
            run_op(ra, rb, 1'($urandom), bit'(n % 7 == 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
